teclado_cajero: RTL and testbench
=================================

# teclado_cajero

Keypad front end for the Cajero ATM controller. It debounces a raw keypad (one key code plus a pressed level) and issues exactly one event per physical key press. In PIN mode it forwards each decimal key as `DIGITO`/`DIGITO_STB`. In amount mode it accumulates decimal keys into a binary `MONTO` and pulses `MONTO_STB` on ENTER. Its outputs drive the same-named inputs of `Cajero` directly.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable cycles required to accept a press or a release (≥2).
- `MAX_DIGITOS`, default 9: maximum decimal digits in an amount (9 keeps the value below 2^32).
- `CLK`, in, 1: single clock; all logic on the rising edge.
- `RESET`, in, 1: synchronous, active-high.
- `TARJETA_RECIBIDA`, in, 1: card present. While low, key events are discarded and the accumulator is held at 0.
- `MODO_MONTO`, in, 1: 0 = PIN entry, 1 = amount entry.
- `TECLA_VALIDA`, in, 1: raw key-pressed level (bouncy).
- `TECLA`, in, 4: raw key code. 0–9 = digit, 0xA = ENTER, 0xB = BORRAR (clear), 0xC–0xF = invalid.
- `DIGITO_STB`, out, 1: one-cycle pulse; `DIGITO` is valid.
- `DIGITO`, out, 4: last accepted PIN digit; held between pulses.
- `MONTO_STB`, out, 1: one-cycle pulse; `MONTO` is valid.
- `MONTO`, out, 32: last committed amount; held between pulses.
- `ERROR_TECLA`, out, 1: one-cycle pulse on a rejected key event.

## Operation
- **Debounce FSM states:**
  - ESPERA
    - `TECLA_VALIDA`=1 → FILTRO. Capture `TECLA` and set the counter to 1.
  - FILTRO
    - Same code, still valid: increment the counter.
    - Code changes while valid: recapture the code and reload the counter to 1.
    - `TECLA_VALIDA`=0 → ESPERA, no event.
    - Counter reaches `DEBOUNCE_CYCLES` → fire the event and go to PRESIONADA.
  - PRESIONADA
    - `TECLA_VALIDA`=0 → LIBERACION, counter = 1.
  - LIBERACION
    - `TECLA_VALIDA`=1 → back to PRESIONADA. No new event.
    - `DEBOUNCE_CYCLES` consecutive low cycles → ESPERA.
- **Event handling** (only when `TARJETA_RECIBIDA`=1):
  - **PIN mode, digit key:** `DIGITO` = code, `DIGITO_STB` = 1.
  - **PIN mode, ENTER/BORRAR/invalid:** `ERROR_TECLA` = 1. No other effect.
  - **Amount mode, digit key:**
    - If digit count < `MAX_DIGITOS`: acc = acc*10 + code, count += 1. acc*10 is computed as (acc<<3)+(acc<<1), 32-bit.
    - Otherwise: `ERROR_TECLA` = 1 and acc is unchanged.
  - **Amount mode, ENTER:**
    - If count > 0: `MONTO` = acc, `MONTO_STB` = 1, then acc = 0, count = 0.
    - If count = 0: `ERROR_TECLA` = 1.
  - **Amount mode, BORRAR:** acc = 0, count = 0. No pulse.
  - **Amount mode, invalid code:** `ERROR_TECLA` = 1.
- **`MODO_MONTO` toggles:** acc and count clear on the cycle after the change. Any partial amount is discarded.
- **`TARJETA_RECIBIDA`=0:**
  - The debounce FSM keeps running, so a held key is not re-fired when the card arrives.
  - Events are dropped silently.
  - acc and count are 0.
- **Strobes:** `DIGITO_STB`, `MONTO_STB` and `ERROR_TECLA` are mutually exclusive. At most one pulse per press.

## Timing
- **Reset values:**
  - `DIGITO_STB`=0, `DIGITO`=0, `MONTO_STB`=0, `MONTO`=0, `ERROR_TECLA`=0.
  - FSM = ESPERA, acc = 0, count = 0.
- **Reset priority:** `RESET` overrides everything on the same edge. Reset mid-press returns to ESPERA. A still-held key is then treated as a new press after `DEBOUNCE_CYCLES` stable cycles.
- **Press latency:**
  - Key stable and valid on sampling edges k … k+N-1 (N = `DEBOUNCE_CYCLES`).
  - Strobe is registered high for the cycle after edge k+N-1, i.e. visible during cycle k+N, for exactly one cycle.
- **Output timing:**
  - `DIGITO`/`MONTO` update on the same edge their strobe rises. They hold until the next strobe of the same kind.
  - All outputs are registered; there are no combinational input-to-output paths.
- **Repeat rate:** minimum spacing between two events is 2N cycles (press filter plus release filter).
- **Glitch rejection:** a glitch shorter than N cycles, in either direction, produces no event.

## Test plan
- **Reset:** `RESET` high 2 cycles with key 5 held → all outputs 0. After release of reset, `DIGITO_STB` fires 4 cycles later with `DIGITO`=5.
- **PIN bounce:** PIN mode, key 7 with 3-cycle bursts separated by 1-cycle drops, then stable 6 cycles, then released 4 cycles → exactly one `DIGITO_STB`, `DIGITO`=7. Pulse appears 4 cycles after the stable run starts.
- **Amount entry:** amount mode, press 1,2,5,0, then ENTER → one `MONTO_STB` with `MONTO`=1250. Second ENTER → `ERROR_TECLA` and `MONTO` stays 1250.
- **Max digits:** enter 9 nines then a tenth 9 → tenth key gives `ERROR_TECLA`. ENTER → `MONTO`=999999999 (0x3B9AC9FF).
- **Clear and mode change:** press 4,2, BORRAR, 8, ENTER → `MONTO`=8. Press 3, toggle `MODO_MONTO` to 0 and back to 1, then ENTER → `ERROR_TECLA`.
- **Card gating:** `TARJETA_RECIBIDA`=0 while pressing 9 → no strobes. Raise `TARJETA_RECIBIDA` while 9 is still held → no event. Release and press 9 again in PIN mode → `DIGITO_STB` with `DIGITO`=9.

Source files
------------

// File: rtl/teclado_cajero_if.sv
// Keypad-side and Cajero-side signals of the teclado_cajero front end.
// slave = the keypad front end, master = whatever drives the raw keypad and card/mode levels.
interface teclado_cajero_if;
  logic        TARJETA_RECIBIDA;
  logic        MODO_MONTO;
  logic        TECLA_VALIDA;
  logic [3:0]  TECLA;
  logic        DIGITO_STB;
  logic [3:0]  DIGITO;
  logic        MONTO_STB;
  logic [31:0] MONTO;
  logic        ERROR_TECLA;

  modport master (
    output TARJETA_RECIBIDA, MODO_MONTO, TECLA_VALIDA, TECLA,
    input  DIGITO_STB, DIGITO, MONTO_STB, MONTO, ERROR_TECLA
  );

  modport slave (
    input  TARJETA_RECIBIDA, MODO_MONTO, TECLA_VALIDA, TECLA,
    output DIGITO_STB, DIGITO, MONTO_STB, MONTO, ERROR_TECLA
  );
endinterface

// File: rtl/teclado_cajero.sv
// Keypad front end for Cajero: debounces the raw keypad, emits one event per press,
// forwards PIN digits and accumulates decimal amounts committed on ENTER.
module teclado_cajero #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned MAX_DIGITOS     = 9
) (
  input logic             CLK,
  input logic             RESET,
  teclado_cajero_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned DIG_W = $clog2(MAX_DIGITOS + 1);
  localparam logic [CNT_W-1:0] CNT_UNO = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FIN = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DIG_W-1:0] DIG_MAX = DIG_W'(MAX_DIGITOS);
  localparam logic [3:0]       TECLA_NUEVE  = 4'h9;
  localparam logic [3:0]       TECLA_ENTER  = 4'hA;
  localparam logic [3:0]       TECLA_BORRAR = 4'hB;

  typedef enum logic [1:0] {
    ESPERA     = 2'd0,
    FILTRO     = 2'd1,
    PRESIONADA = 2'd2,
    LIBERACION = 2'd3
  } estado_t;

  estado_t          estado, estado_sig;
  logic [CNT_W-1:0] cnt, cnt_sig;
  logic [3:0]       codigo, codigo_sig;

  logic             evento_c;
  logic             cambio_modo_c;
  logic [31:0]      acc, acc_base_c, acc_x10_c, acc_sig;
  logic [DIG_W-1:0] cuenta, cuenta_base_c, cuenta_sig;
  logic             modo_prev;

  logic             digito_stb_q, digito_stb_sig;
  logic [3:0]       digito_q, digito_sig;
  logic             monto_stb_q, monto_stb_sig;
  logic [31:0]      monto_q, monto_sig;
  logic             error_q, error_sig;

  // Debounce state register
  always_ff @(posedge CLK) begin
    if (RESET) begin
      estado <= ESPERA;
      cnt    <= '0;
      codigo <= '0;
    end else begin
      estado <= estado_sig;
      cnt    <= cnt_sig;
      codigo <= codigo_sig;
    end
  end

  // Debounce next state: press filter, held, release filter
  always_comb begin
    estado_sig = estado;
    cnt_sig    = cnt;
    codigo_sig = codigo;
    case (estado)
      ESPERA: begin
        if (bus.TECLA_VALIDA) begin
          estado_sig = FILTRO;
          codigo_sig = bus.TECLA;
          cnt_sig    = CNT_UNO;
        end
      end
      FILTRO: begin
        if (!bus.TECLA_VALIDA) begin
          estado_sig = ESPERA;
          cnt_sig    = '0;
        end else if (bus.TECLA != codigo) begin
          codigo_sig = bus.TECLA;
          cnt_sig    = CNT_UNO;
        end else if (cnt == CNT_FIN) begin
          estado_sig = PRESIONADA;
          cnt_sig    = '0;
        end else begin
          cnt_sig = cnt + CNT_UNO;
        end
      end
      PRESIONADA: begin
        if (!bus.TECLA_VALIDA) begin
          estado_sig = LIBERACION;
          cnt_sig    = CNT_UNO;
        end
      end
      LIBERACION: begin
        if (bus.TECLA_VALIDA) begin
          estado_sig = PRESIONADA;
          cnt_sig    = '0;
        end else if (cnt == CNT_FIN) begin
          estado_sig = ESPERA;
          cnt_sig    = '0;
        end else begin
          cnt_sig = cnt + CNT_UNO;
        end
      end
      default: begin
        estado_sig = ESPERA;
        cnt_sig    = '0;
      end
    endcase
  end

  // Event decode and next values for the accumulator and registered outputs
  always_comb begin
    evento_c = (estado == FILTRO) && bus.TECLA_VALIDA &&
               (bus.TECLA == codigo) && (cnt == CNT_FIN);
    cambio_modo_c = (bus.MODO_MONTO != modo_prev);

    // A missing card or a mode change discards any partial amount
    if (!bus.TARJETA_RECIBIDA || cambio_modo_c) begin
      acc_base_c    = '0;
      cuenta_base_c = '0;
    end else begin
      acc_base_c    = acc;
      cuenta_base_c = cuenta;
    end
    acc_x10_c = (acc_base_c << 3) + (acc_base_c << 1);

    acc_sig        = acc_base_c;
    cuenta_sig     = cuenta_base_c;
    digito_stb_sig = 1'b0;
    digito_sig     = digito_q;
    monto_stb_sig  = 1'b0;
    monto_sig      = monto_q;
    error_sig      = 1'b0;

    if (evento_c && bus.TARJETA_RECIBIDA) begin
      if (!bus.MODO_MONTO) begin
        if (codigo <= TECLA_NUEVE) begin
          digito_stb_sig = 1'b1;
          digito_sig     = codigo;
        end else begin
          error_sig = 1'b1;
        end
      end else if (codigo <= TECLA_NUEVE) begin
        if (cuenta_base_c < DIG_MAX) begin
          acc_sig    = acc_x10_c + 32'(codigo);
          cuenta_sig = cuenta_base_c + DIG_W'(1);
        end else begin
          error_sig = 1'b1;
        end
      end else if (codigo == TECLA_ENTER) begin
        if (cuenta_base_c != '0) begin
          monto_stb_sig = 1'b1;
          monto_sig     = acc_base_c;
          acc_sig       = '0;
          cuenta_sig    = '0;
        end else begin
          error_sig = 1'b1;
        end
      end else if (codigo == TECLA_BORRAR) begin
        acc_sig    = '0;
        cuenta_sig = '0;
      end else begin
        error_sig = 1'b1;
      end
    end
  end

  // Accumulator and output registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      acc          <= '0;
      cuenta       <= '0;
      modo_prev    <= 1'b0;
      digito_stb_q <= 1'b0;
      digito_q     <= '0;
      monto_stb_q  <= 1'b0;
      monto_q      <= '0;
      error_q      <= 1'b0;
    end else begin
      acc          <= acc_sig;
      cuenta       <= cuenta_sig;
      modo_prev    <= bus.MODO_MONTO;
      digito_stb_q <= digito_stb_sig;
      digito_q     <= digito_sig;
      monto_stb_q  <= monto_stb_sig;
      monto_q      <= monto_sig;
      error_q      <= error_sig;
    end
  end

  assign bus.DIGITO_STB  = digito_stb_q;
  assign bus.DIGITO      = digito_q;
  assign bus.MONTO_STB   = monto_stb_q;
  assign bus.MONTO       = monto_q;
  assign bus.ERROR_TECLA = error_q;

endmodule

// File: tb/tb_teclado_cajero.sv
// Directed bench for teclado_cajero with DEBOUNCE_CYCLES=4, MAX_DIGITOS=9.
module tb_teclado_cajero;

  logic CLK = 1'b0;
  logic RESET;

  always #5 CLK = ~CLK;

  teclado_cajero_if bus();

  teclado_cajero #(
    .DEBOUNCE_CYCLES(4),
    .MAX_DIGITOS    (9)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int n_dig = 0;
  int n_mon = 0;
  int n_err = 0;

  // Strobe tally plus mutual-exclusion check
  always @(negedge CLK) begin
    if (!RESET) begin
      if (bus.DIGITO_STB)  n_dig++;
      if (bus.MONTO_STB)   n_mon++;
      if (bus.ERROR_TECLA) n_err++;
      if (bus.DIGITO_STB || bus.MONTO_STB || bus.ERROR_TECLA) begin
        vectors++;
        if (int'(bus.DIGITO_STB) + int'(bus.MONTO_STB) + int'(bus.ERROR_TECLA) > 1) begin
          miscompares++;
          $display("FAIL strobe_exclusive: got dig=%0b mon=%0b err=%0b expected at most one high",
                   bus.DIGITO_STB, bus.MONTO_STB, bus.ERROR_TECLA);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic press_key(input logic [3:0] c);
    bus.TECLA        = c;
    bus.TECLA_VALIDA = 1'b1;
    step(5);
    bus.TECLA_VALIDA = 1'b0;
    step(5);
  endtask

  task automatic test_reset();
    RESET                = 1'b1;
    bus.TARJETA_RECIBIDA = 1'b1;
    bus.MODO_MONTO       = 1'b0;
    bus.TECLA            = 4'd5;
    bus.TECLA_VALIDA     = 1'b1;
    step(2);
    vectors++; if (bus.DIGITO_STB !== 1'b0) begin miscompares++; $display("FAIL reset_digito_stb: got %0b expected 0", bus.DIGITO_STB); end
    vectors++; if (bus.DIGITO !== 4'd0) begin miscompares++; $display("FAIL reset_digito: got %0d expected 0", bus.DIGITO); end
    vectors++; if (bus.MONTO_STB !== 1'b0) begin miscompares++; $display("FAIL reset_monto_stb: got %0b expected 0", bus.MONTO_STB); end
    vectors++; if (bus.MONTO !== 32'd0) begin miscompares++; $display("FAIL reset_monto: got %0d expected 0", bus.MONTO); end
    vectors++; if (bus.ERROR_TECLA !== 1'b0) begin miscompares++; $display("FAIL reset_error: got %0b expected 0", bus.ERROR_TECLA); end
    RESET = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      vectors++; if (bus.DIGITO_STB !== 1'b0) begin miscompares++; $display("FAIL reset_early_stb: cycle %0d got %0b expected 0", i, bus.DIGITO_STB); end
    end
    step(1);
    vectors++; if (bus.DIGITO_STB !== 1'b1) begin miscompares++; $display("FAIL reset_held_stb: got %0b expected 1", bus.DIGITO_STB); end
    vectors++; if (bus.DIGITO !== 4'd5) begin miscompares++; $display("FAIL reset_held_digito: got %0d expected 5", bus.DIGITO); end
    step(1);
    vectors++; if (bus.DIGITO_STB !== 1'b0) begin miscompares++; $display("FAIL reset_stb_width: got %0b expected 0", bus.DIGITO_STB); end
    bus.TECLA_VALIDA = 1'b0;
    step(5);
  endtask

  task automatic test_pin_bounce();
    int d0;
    d0 = n_dig;
    bus.TECLA = 4'd7;
    for (int b = 0; b < 2; b++) begin
      bus.TECLA_VALIDA = 1'b1;
      step(3);
      bus.TECLA_VALIDA = 1'b0;
      step(1);
    end
    bus.TECLA_VALIDA = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      vectors++; if (bus.DIGITO_STB !== 1'b0) begin miscompares++; $display("FAIL bounce_early_stb: cycle %0d got %0b expected 0", i, bus.DIGITO_STB); end
    end
    step(1);
    vectors++; if (bus.DIGITO_STB !== 1'b1) begin miscompares++; $display("FAIL bounce_stb: got %0b expected 1", bus.DIGITO_STB); end
    vectors++; if (bus.DIGITO !== 4'd7) begin miscompares++; $display("FAIL bounce_digito: got %0d expected 7", bus.DIGITO); end
    step(2);
    bus.TECLA_VALIDA = 1'b0;
    step(4);
    vectors++; if (n_dig - d0 !== 1) begin miscompares++; $display("FAIL bounce_count: got %0d expected 1", n_dig - d0); end
  endtask

  task automatic test_glitch();
    int d0;
    d0 = n_dig;
    bus.TECLA        = 4'd6;
    bus.TECLA_VALIDA = 1'b1;
    step(3);
    bus.TECLA_VALIDA = 1'b0;
    step(5);
    vectors++; if (n_dig - d0 !== 0) begin miscompares++; $display("FAIL glitch_press: got %0d events expected 0", n_dig - d0); end
    bus.TECLA_VALIDA = 1'b1;
    step(5);
    bus.TECLA_VALIDA = 1'b0;
    step(2);
    bus.TECLA_VALIDA = 1'b1;
    step(3);
    bus.TECLA_VALIDA = 1'b0;
    step(5);
    vectors++; if (n_dig - d0 !== 1) begin miscompares++; $display("FAIL glitch_release: got %0d events expected 1", n_dig - d0); end
    vectors++; if (bus.DIGITO !== 4'd6) begin miscompares++; $display("FAIL glitch_digito: got %0d expected 6", bus.DIGITO); end
  endtask

  task automatic test_amount();
    int d0, m0, e0;
    bus.MODO_MONTO = 1'b1;
    step(2);
    d0 = n_dig; m0 = n_mon; e0 = n_err;
    press_key(4'd1);
    press_key(4'd2);
    press_key(4'd5);
    press_key(4'd0);
    press_key(4'hA);
    vectors++; if (n_mon - m0 !== 1) begin miscompares++; $display("FAIL amount_stb_count: got %0d expected 1", n_mon - m0); end
    vectors++; if (bus.MONTO !== 32'd1250) begin miscompares++; $display("FAIL amount_value: got %0d expected 1250", bus.MONTO); end
    vectors++; if (n_err - e0 !== 0) begin miscompares++; $display("FAIL amount_no_error: got %0d expected 0", n_err - e0); end
    vectors++; if (n_dig - d0 !== 0) begin miscompares++; $display("FAIL amount_no_digito: got %0d expected 0", n_dig - d0); end
    press_key(4'hA);
    vectors++; if (n_err - e0 !== 1) begin miscompares++; $display("FAIL amount_empty_enter: got %0d errors expected 1", n_err - e0); end
    vectors++; if (n_mon - m0 !== 1) begin miscompares++; $display("FAIL amount_empty_no_stb: got %0d expected 1", n_mon - m0); end
    vectors++; if (bus.MONTO !== 32'd1250) begin miscompares++; $display("FAIL amount_hold: got %0d expected 1250", bus.MONTO); end
  endtask

  task automatic test_max_digits();
    int m0, e0;
    repeat (9) press_key(4'd9);
    e0 = n_err;
    press_key(4'd9);
    vectors++; if (n_err - e0 !== 1) begin miscompares++; $display("FAIL max_tenth_error: got %0d expected 1", n_err - e0); end
    m0 = n_mon;
    press_key(4'hA);
    vectors++; if (n_mon - m0 !== 1) begin miscompares++; $display("FAIL max_stb: got %0d expected 1", n_mon - m0); end
    vectors++; if (bus.MONTO !== 32'h3B9AC9FF) begin miscompares++; $display("FAIL max_value: got %0d expected 999999999", bus.MONTO); end
  endtask

  task automatic test_clear_mode();
    int m0, e0;
    press_key(4'd4);
    press_key(4'd2);
    press_key(4'hB);
    press_key(4'd8);
    press_key(4'hA);
    vectors++; if (bus.MONTO !== 32'd8) begin miscompares++; $display("FAIL clear_value: got %0d expected 8", bus.MONTO); end
    press_key(4'd3);
    bus.MODO_MONTO = 1'b0;
    step(2);
    bus.MODO_MONTO = 1'b1;
    step(2);
    m0 = n_mon; e0 = n_err;
    press_key(4'hA);
    vectors++; if (n_err - e0 !== 1) begin miscompares++; $display("FAIL mode_discard_error: got %0d expected 1", n_err - e0); end
    vectors++; if (n_mon - m0 !== 0) begin miscompares++; $display("FAIL mode_discard_stb: got %0d expected 0", n_mon - m0); end
    vectors++; if (bus.MONTO !== 32'd8) begin miscompares++; $display("FAIL mode_monto_hold: got %0d expected 8", bus.MONTO); end
  endtask

  task automatic test_card();
    int d0, m0, e0;
    bus.MODO_MONTO       = 1'b0;
    bus.TARJETA_RECIBIDA = 1'b0;
    step(2);
    d0 = n_dig; m0 = n_mon; e0 = n_err;
    bus.TECLA        = 4'd9;
    bus.TECLA_VALIDA = 1'b1;
    step(6);
    bus.TARJETA_RECIBIDA = 1'b1;
    step(6);
    bus.TECLA_VALIDA = 1'b0;
    step(5);
    vectors++; if (n_dig - d0 !== 0) begin miscompares++; $display("FAIL card_held_digito: got %0d expected 0", n_dig - d0); end
    vectors++; if (n_mon - m0 + n_err - e0 !== 0) begin miscompares++; $display("FAIL card_held_other: got %0d expected 0", n_mon - m0 + n_err - e0); end
    press_key(4'd9);
    vectors++; if (n_dig - d0 !== 1) begin miscompares++; $display("FAIL card_press_stb: got %0d expected 1", n_dig - d0); end
    vectors++; if (bus.DIGITO !== 4'd9) begin miscompares++; $display("FAIL card_press_digito: got %0d expected 9", bus.DIGITO); end
    bus.MODO_MONTO = 1'b1;
    step(2);
    press_key(4'd5);
    bus.TARJETA_RECIBIDA = 1'b0;
    step(2);
    bus.TARJETA_RECIBIDA = 1'b1;
    step(2);
    e0 = n_err;
    press_key(4'hA);
    vectors++; if (n_err - e0 !== 1) begin miscompares++; $display("FAIL card_acc_cleared: got %0d expected 1", n_err - e0); end
    vectors++; if (bus.MONTO !== 32'd8) begin miscompares++; $display("FAIL card_monto_hold: got %0d expected 8", bus.MONTO); end
  endtask

  initial begin
    test_reset();
    test_pin_bounce();
    test_glitch();
    test_amount();
    test_max_digits();
    test_clear_mode();
    test_card();
    step(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
